// File: rtl/hps_frame_scheduler.sv
// rtl/hps_frame_scheduler.sv - ping-pong bank scheduler between the FFT magnitude stream and the HPS sweep
// Write side steers first-half bins into a free bank; read side launches sweeps on completed banks, oldest first.
module hps_frame_scheduler #(
    parameter int K_WIDTH   = 11,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 frame_tvalid,
    input  logic                 frame_tlast,
    input  logic [K_WIDTH-1:0]   frame_k,
    output logic                 wr_en,
    output logic                 wr_bank,
    output logic [K_WIDTH-2:0]   wr_addr,
    output logic                 sweep_start,
    output logic                 sweep_bank,
    input  logic                 sweep_done,
    output logic [1:0]           bank_full,
    output logic                 frame_dropped,
    output logic [CNT_WIDTH-1:0] drop_count
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_state_t;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
    typedef enum logic {R_IDLE, R_BUSY} rd_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    wr_state_t   w_state, w_d;
    rd_state_t   r_state, r_d;
    logic        fill_bank, fill_d;
    logic        last_filled, last_d;
    logic        start_bank, any_empty, full_found, full_pick;
    logic        wr_en_d, wr_bank_d, sweep_start_d, sweep_bank_d, drop_d;
    logic [K_WIDTH-2:0]   wr_addr_d;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [1:0]           bank_full_d;

    // Frame-start decisions use the current bank states, so a bank freed by
    // sweep_done this cycle is still READING to the write side.
    always_comb begin
        any_empty = (bank_q[0] == B_EMPTY) || (bank_q[1] == B_EMPTY);
        if ((bank_q[0] == B_EMPTY) && (bank_q[1] == B_EMPTY))
            start_bank = ~last_filled;
        else
            start_bank = (bank_q[0] == B_EMPTY) ? 1'b0 : 1'b1;
    end

    always_comb begin
        bank_d[0]     = bank_q[0];
        bank_d[1]     = bank_q[1];
        w_d           = w_state;
        r_d           = r_state;
        fill_d        = fill_bank;
        last_d        = last_filled;
        wr_en_d       = 1'b0;
        wr_bank_d     = wr_bank;
        wr_addr_d     = wr_addr;
        drop_d        = 1'b0;
        cnt_d         = drop_count;
        sweep_start_d = 1'b0;
        sweep_bank_d  = sweep_bank;
        full_found    = 1'b0;
        full_pick     = 1'b0;

        if (frame_tvalid) begin
            if ((w_state == W_FILL) || (frame_k == '0)) begin
                if ((w_state != W_FILL) && any_empty) begin
                    bank_d[start_bank] = B_FILLING;
                    fill_d             = start_bank;
                    w_d                = W_FILL;
                end else if (w_state != W_FILL) begin
                    w_d    = W_DROP;
                    drop_d = 1'b1;
                    if (drop_count != '1)
                        cnt_d = drop_count + 1'b1;
                end
                if ((w_d == W_FILL) && !frame_k[K_WIDTH-1]) begin
                    wr_en_d   = 1'b1;
                    wr_bank_d = fill_d;
                    wr_addr_d = frame_k[K_WIDTH-2:0];
                end
            end
            if (frame_tlast && (w_d == W_FILL)) begin
                bank_d[fill_d] = B_FULL;
                last_d         = fill_d;
                w_d            = W_IDLE;
            end else if (frame_tlast && (w_d == W_DROP)) begin
                w_d = W_IDLE;
            end
        end

        if ((r_state == R_BUSY) && sweep_done) begin
            bank_d[sweep_bank] = B_EMPTY;
            r_d                = R_IDLE;
        end

        // Chain straight into the next sweep so a waiting bank starts the cycle after sweep_done.
        if (r_d == R_IDLE) begin
            if ((bank_d[0] == B_FULL) && (bank_d[1] == B_FULL)) begin
                full_found = 1'b1;
                full_pick  = ~last_d;
            end else if (bank_d[0] == B_FULL) begin
                full_found = 1'b1;
                full_pick  = 1'b0;
            end else if (bank_d[1] == B_FULL) begin
                full_found = 1'b1;
                full_pick  = 1'b1;
            end
            if (full_found) begin
                bank_d[full_pick] = B_READING;
                sweep_start_d     = 1'b1;
                sweep_bank_d      = full_pick;
                r_d               = R_BUSY;
            end
        end

        bank_full_d[0] = (bank_d[0] == B_FULL) || (bank_d[0] == B_READING);
        bank_full_d[1] = (bank_d[1] == B_FULL) || (bank_d[1] == B_READING);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_q[0]     <= B_EMPTY;
            bank_q[1]     <= B_EMPTY;
            w_state       <= W_IDLE;
            r_state       <= R_IDLE;
            fill_bank     <= 1'b0;
            last_filled   <= 1'b1;
            wr_en         <= 1'b0;
            wr_bank       <= 1'b0;
            wr_addr       <= '0;
            sweep_start   <= 1'b0;
            sweep_bank    <= 1'b0;
            bank_full     <= 2'b00;
            frame_dropped <= 1'b0;
            drop_count    <= '0;
        end else begin
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            w_state       <= w_d;
            r_state       <= r_d;
            fill_bank     <= fill_d;
            last_filled   <= last_d;
            wr_en         <= wr_en_d;
            wr_bank       <= wr_bank_d;
            wr_addr       <= wr_addr_d;
            sweep_start   <= sweep_start_d;
            sweep_bank    <= sweep_bank_d;
            bank_full     <= bank_full_d;
            frame_dropped <= drop_d;
            drop_count    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hps_frame_scheduler.sv
// tb/tb_hps_frame_scheduler.sv - directed self-checking bench for hps_frame_scheduler
module tb_hps_frame_scheduler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tvalid = 1'b0;
    logic        frame_tlast = 1'b0;
    logic [10:0] frame_k = '0;
    logic        sweep_done = 1'b0;
    logic        wr_en, wr_bank, sweep_start, sweep_bank, frame_dropped;
    logic [9:0]  wr_addr;
    logic [1:0]  bank_full;
    logic [15:0] drop_count;

    int n_pass = 0;
    int n_total = 0;
    int nwr, errs, nstart, ndrop;

    hps_frame_scheduler #(.K_WIDTH(11), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .frame_tvalid(frame_tvalid), .frame_tlast(frame_tlast), .frame_k(frame_k),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .sweep_start(sweep_start), .sweep_bank(sweep_bank), .sweep_done(sweep_done),
        .bank_full(bank_full), .frame_dropped(frame_dropped), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // exp_bank < 0 means no beat of this burst may write.
    task automatic send(input int k0, input int n, input bit tl, input int exp_bank,
                        output int o_nwr, output int o_errs, output int o_nstart, output int o_ndrop);
        o_nwr = 0; o_errs = 0; o_nstart = 0; o_ndrop = 0;
        for (int i = 0; i < n; i++) begin
            int k;
            k = k0 + i;
            frame_tvalid = 1'b1;
            frame_k      = k[10:0];
            frame_tlast  = tl && (i == n - 1);
            tick();
            if (wr_en) begin
                o_nwr++;
                if (exp_bank < 0 || k >= 1024 || wr_bank != exp_bank[0] || wr_addr != k[9:0])
                    o_errs++;
            end else if (exp_bank >= 0 && k < 1024) begin
                o_errs++;
            end
            o_nstart += int'(sweep_start);
            o_ndrop  += int'(frame_dropped);
        end
        frame_tvalid = 1'b0;
        frame_tlast  = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_sweep_start", sweep_start, 0);
        check("rst_bank_full", bank_full, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_frame_dropped", frame_dropped, 0);
        reset_n = 1'b1;
        tick();

        send(0, 2048, 1, 0, nwr, errs, nstart, ndrop);
        check("f1_nwr", nwr, 1024);
        check("f1_errs", errs, 0);
        check("f1_start", sweep_start, 1);
        check("f1_sbank", sweep_bank, 0);
        check("f1_nstart", nstart, 1);
        check("f1_full", bank_full, 2'b01);
        tick();
        check("f1_start_pulse", sweep_start, 0);
        sweep_done = 1'b1;
        #1;
        check("f1_full_done_cyc", bank_full, 2'b01);
        tick();
        sweep_done = 1'b0;
        check("f1_full_after", bank_full, 2'b00);

        // Back-to-back frames; last fill was bank 0 so the next goes to bank 1.
        send(0, 2048, 1, 1, nwr, errs, nstart, ndrop);
        check("fa_errs", errs, 0);
        check("fa_sbank", sweep_bank, 1);
        send(0, 2048, 1, 0, nwr, errs, nstart, ndrop);
        check("fb_nwr", nwr, 1024);
        check("fb_errs", errs, 0);
        check("fb_nstart", nstart, 0);
        check("fb_full", bank_full, 2'b11);
        sweep_done = 1'b1;
        tick();
        sweep_done = 1'b0;
        check("fb_chain_start", sweep_start, 1);
        check("fb_chain_bank", sweep_bank, 0);
        check("fb_chain_full", bank_full, 2'b01);

        send(0, 2048, 1, 1, nwr, errs, nstart, ndrop);
        check("fc_errs", errs, 0);
        check("fc_nstart", nstart, 0);
        send(0, 2048, 1, -1, nwr, errs, nstart, ndrop);
        check("fd_nwr", nwr, 0);
        check("fd_ndrop", ndrop, 1);
        check("fd_count", drop_count, 1);
        sweep_done = 1'b1;
        tick();
        sweep_done = 1'b0;
        check("fd_next_start", sweep_start, 1);
        check("fd_next_bank", sweep_bank, 1);
        tick();
        sweep_done = 1'b1;
        tick();
        sweep_done = 1'b0;
        check("fd_all_empty", bank_full, 2'b00);

        // Asynchronous reset in the middle of a fill.
        send(0, 100, 0, 0, nwr, errs, nstart, ndrop);
        check("mf_wr_en_before", wr_en, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mf_wr_en_async", wr_en, 0);
        check("mf_count_async", drop_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Missing tlast: restart in the same bank from address 0.
        send(0, 300, 0, 0, nwr, errs, nstart, ndrop);
        check("rs_part_nwr", nwr, 300);
        check("rs_part_errs", errs, 0);
        send(0, 2048, 1, 0, nwr, errs, nstart, ndrop);
        check("rs_nwr", nwr, 1024);
        check("rs_errs", errs, 0);
        check("rs_nstart", nstart, 1);
        check("rs_sbank", sweep_bank, 0);
        check("rs_count", drop_count, 0);

        // Asynchronous reset in the middle of a sweep.
        tick();
        tick();
        #1 reset_n = 1'b0;
        #1;
        check("ms_full_async", bank_full, 2'b00);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Stream joins mid-frame: nothing written, tlast ignored.
        send(500, 1548, 1, -1, nwr, errs, nstart, ndrop);
        check("mid_nwr", nwr, 0);
        check("mid_errs", errs, 0);
        tick();
        check("mid_full", bank_full, 2'b00);
        send(0, 2048, 1, 0, nwr, errs, nstart, ndrop);
        check("fresh_errs", errs, 0);
        check("fresh_start", sweep_start, 1);
        check("fresh_sbank", sweep_bank, 0);

        // One-beat frame while bank 0 is being swept.
        send(0, 1, 1, 1, nwr, errs, nstart, ndrop);
        check("one_nwr", nwr, 1);
        check("one_errs", errs, 0);
        check("one_full", bank_full, 2'b11);
        check("one_nostart", sweep_start, 0);
        sweep_done = 1'b1;
        tick();
        sweep_done = 1'b0;
        check("one_start", sweep_start, 1);
        check("one_sbank", sweep_bank, 1);

        // Frame start coinciding with sweep_done still sees the bank as busy.
        send(0, 1, 1, 0, nwr, errs, nstart, ndrop);
        check("sim_fill_errs", errs, 0);
        sweep_done = 1'b1;
        send(0, 1, 1, -1, nwr, errs, nstart, ndrop);
        sweep_done = 1'b0;
        check("sim_nwr", nwr, 0);
        check("sim_drop", frame_dropped, 1);
        check("sim_count", drop_count, 1);
        check("sim_start", sweep_start, 1);
        check("sim_sbank", sweep_bank, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
